// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_t    : loader controller states
//   IMEM_DEPTH : default number of 32-bit words in instruction memory
//   HDR_LEN    : frame header length in bytes (word count, little-endian)
//   CSUM_LEN   : frame trailer length in bytes (XOR checksum)
//   word2byte  : word index -> word-aligned byte address
package imem_loader_pkg;

    localparam int IMEM_DEPTH = 64;
    localparam int HDR_LEN    = 2;
    localparam int CSUM_LEN   = 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    function automatic logic [31:0] word2byte(input logic [29:0] widx);
        return {widx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_pack.sv
// imem_word_pack: assembles four stream bytes into a little-endian 32-bit word.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset
//   clr_i       : restart assembly at lane 0 (new load)
//   load_i      : accept byte_i into the current lane
//   byte_i      : stream byte
//   word_o      : assembled word (held stable until the next load)
//   word_full_o : the current lane is the last one, so a load now completes the word
module imem_word_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
        end else if (clr_i) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
        end else if (load_i) begin
            word_q[8*byte_cnt_q +: 8] <= byte_i;
            byte_cnt_q                <= byte_cnt_q + 2'd1;
        end
    end

    // Depends only on the counter so the controller can use it without a
    // combinational path back through load_i.
    assign word_full_o = (byte_cnt_q == 2'd3);
    assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for a 32-bit word-addressed instruction memory.
// Receives a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes LSB first,
// XOR checksum) and issues one-cycle write strobes while holding the CPU in reset.
//   clk, reset            : clock, asynchronous active-low reset
//   start                 : begin a load (honoured in IDLE/DONE/ERR)
//   byte_valid/byte_data  : stream input, transfer when byte_ready is also high
//   byte_ready            : loader can accept a byte this cycle
//   we/wa/wd              : memory write strobe, byte address, data
//   cpu_hold/busy         : processor held in reset / load in progress
//   done/error            : sticky load result flags
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             hold_q, hold_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             pack_clr;
    logic             pack_load;
    logic             word_full;
    logic             last_word;
    logic [CNT_W-1:0] n_full;

    assign accept    = byte_valid && byte_ready;
    assign n_full    = CNT_W'({byte_data, n_q[7:0]});
    assign last_word = (CNT_W'(idx_q) == (n_q - 1'b1));

    imem_word_pack u_pack (
        .clk_i       (clk),
        .rst_ni      (reset),
        .clr_i       (pack_clr),
        .load_i      (pack_load),
        .byte_i      (byte_data),
        .word_o      (wd),
        .word_full_o (word_full)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            csum_q  <= 8'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        pack_clr  = 1'b0;
        pack_load = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = LEN_LO;
                    n_d      = '0;
                    idx_d    = '0;
                    csum_d   = 8'd0;
                    pack_clr = 1'b1;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    n_d     = CNT_W'(byte_data);
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full > CNT_W'(DEPTH)) begin
                        state_d = ERR;
                    end else if (n_full == '0) begin
                        state_d = CHECK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    pack_load = 1'b1;
                    csum_d    = csum_q ^ byte_data;
                    if (word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = CHECK;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DATA;
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (byte_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: byte_ready decodes the current state, the rest are computed
    // from the next state so the registered copies line up with the state.
    always_comb begin
        byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                     (state_q == DATA)   || (state_q == CHECK);
        we_d       = (state_d == WRITE);
        busy_d     = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                     (state_d == DATA)   || (state_d == WRITE)  ||
                     (state_d == CHECK);
        hold_d     = busy_d || (state_d == ERR);
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
    end

    assign we       = we_q;
    assign wa       = word2byte(30'(idx_q));
    assign cpu_hold = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table-driven frames plus hand-written sequences
// for full depth with stalls, reset mid-word, and ignored mid-load start.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write monitor
    int          wr_cnt = 0;
    logic [31:0] wa_log [0:127];
    logic [31:0] wd_log [0:127];

    always @(negedge clk) begin
        if (reset && we) begin
            if (wr_cnt < 128) begin
                wa_log[wr_cnt] = wa;
                wd_log[wr_cnt] = wd;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_byte timeout: byte %h, byte_ready stayed %b", b, byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    typedef struct {
        string        name;
        int           nb;
        logic [95:0]  bytes;   // byte i at [8*(11-i) +: 8], sent left to right
        int           nw;
        logic [31:0]  wd0;
        logic [31:0]  wd1;
        logic         dn;
        logic         er;
    } vec_t;

    vec_t vecs [0:6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        logic [31:0] exp_w [0:63];

        vecs[0] = '{"nominal",   11, 96'h02_00_13_00_10_00_93_00_20_00_B0_00, 2, 32'h00100013, 32'h00200093, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum",  11, 96'h02_00_13_00_10_00_93_00_20_00_00_00, 2, 32'h00100013, 32'h00200093, 1'b0, 1'b1};
        vecs[2] = '{"oversize",   2, 96'h41_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{"len_hi_big", 2, 96'h00_01_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[4] = '{"empty",      3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[5] = '{"empty_bad",  3, 96'h00_00_5A_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[6] = '{"one_word",   7, 96'h01_00_EF_BE_AD_DE_22_00_00_00_00_00, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_ready", byte_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", byte_ready, 0);

        // Table-driven frames
        for (int i = 0; i < 7; i++) begin
            wr_cnt = 0;
            pulse_start();
            check({vecs[i].name, "_busy_at_start"}, busy, 1);
            check({vecs[i].name, "_hold_at_start"}, cpu_hold, 1);
            check({vecs[i].name, "_done_cleared"}, done, 0);
            check({vecs[i].name, "_err_cleared"}, error, 0);
            for (int k = 0; k < vecs[i].nb; k++) begin
                send_byte(vecs[i].bytes[8*(11-k) +: 8], k % 3);
            end
            repeat (3) @(negedge clk);
            check({vecs[i].name, "_writes"}, wr_cnt, vecs[i].nw);
            check({vecs[i].name, "_done"}, done, vecs[i].dn);
            check({vecs[i].name, "_error"}, error, vecs[i].er);
            check({vecs[i].name, "_hold"}, cpu_hold, vecs[i].er);
            check({vecs[i].name, "_busy"}, busy, 0);
            check({vecs[i].name, "_ready"}, byte_ready, 0);
            if (vecs[i].nw > 0) begin
                check({vecs[i].name, "_wa0"}, wa_log[0], 32'h0);
                check({vecs[i].name, "_wd0"}, wd_log[0], vecs[i].wd0);
            end
            if (vecs[i].nw > 1) begin
                check({vecs[i].name, "_wa1"}, wa_log[1], 32'h4);
                check({vecs[i].name, "_wd1"}, wd_log[1], vecs[i].wd1);
            end
        end

        // DONE does not consume bytes
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("done_ready", byte_ready, 0);
        check("done_sticky", done, 1);
        check("done_no_write", wr_cnt, 1);
        byte_valid = 1'b0;

        // Full depth with random stalls
        wr_cnt = 0;
        cs = 8'h00;
        pulse_start();
        send_byte(8'h40, 0);
        send_byte(8'h00, 1);
        for (int j = 0; j < 64; j++) begin
            w = {8'(j * 7 + 1), ~8'(j), 8'(j) ^ 8'h5A, 8'(j)};
            exp_w[j] = w;
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], int'($urandom_range(0, 3)));
            end
        end
        send_byte(cs, 2);
        repeat (3) @(negedge clk);
        check("full_writes", wr_cnt, 64);
        check("full_done", done, 1);
        check("full_error", error, 0);
        check("full_hold", cpu_hold, 0);
        check("full_last_wa", wa_log[63], 32'hFC);
        for (int j = 0; j < 64; j++) begin
            check($sformatf("full_wa%0d", j), wa_log[j], 32'(j * 4));
            check($sformatf("full_wd%0d", j), wd_log[j], exp_w[j]);
        end

        // Reset mid-word
        wr_cnt = 0;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        check("mid_busy", busy, 1);
        check("mid_hold", cpu_hold, 1);
        check("mid_ready", byte_ready, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_we", we, 0);
        check("arst_wa", wa, 0);
        check("arst_wd", wd, 0);
        check("arst_hold", cpu_hold, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        check("arst_ready", byte_ready, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("arst_no_write", wr_cnt, 0);

        // Restart with start pulses injected mid-load
        pulse_start();
        send_byte(8'h02, 0);
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h93, 0);
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        pulse_start();
        send_byte(8'h00, 0);
        pulse_start();
        send_byte(8'hB0, 0);
        repeat (3) @(negedge clk);
        check("restart_writes", wr_cnt, 2);
        check("restart_wa0", wa_log[0], 32'h0);
        check("restart_wd0", wd_log[0], 32'h00100013);
        check("restart_wa1", wa_log[1], 32'h4);
        check("restart_wd1", wd_log[1], 32'h00200093);
        check("restart_done", done, 1);
        check("restart_error", error, 0);
        check("restart_hold", cpu_hold, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
